// File: rtl/comparador_izq_der.sv
// Serial unsigned magnitude comparator: scans captured words MSB to LSB, one bit per cycle,
// and reports A <= B, A == B and the index of the first differing bit.
module comparador_izq_der #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     start,
    input  logic [WIDTH-1:0]         wordA,
    input  logic [WIDTH-1:0]         wordB,
    output logic                     busy,
    output logic                     done,
    output logic                     z,
    output logic                     eq,
    output logic [$clog2(WIDTH)-1:0] pos
);

    localparam int unsigned PW = $clog2(WIDTH);
    localparam logic [PW-1:0] IdxTop = PW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic             z_q, z_d;
    logic             eq_q, eq_d;
    logic [PW-1:0]    pos_q, pos_d;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IdxTop;
            z_q     <= 1'b0;
            eq_q    <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            eq_q    <= eq_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        z_d     = z_q;
        eq_d    = eq_q;
        pos_d   = pos_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = wordA;
                    b_d     = wordB;
                    idx_d   = IdxTop;
                    state_d = StScan;
                end
            end
            StScan: begin
                // The first differing bit from the left decides the unsigned ordering.
                if (a_q[idx_q] != b_q[idx_q]) begin
                    z_d     = ~a_q[idx_q] & b_q[idx_q];
                    eq_d    = 1'b0;
                    pos_d   = idx_q;
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    z_d     = 1'b1;
                    eq_d    = 1'b1;
                    pos_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - PW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign z    = z_q;
    assign eq   = eq_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_comparador_izq_der.sv
// Bench for comparador_izq_der: cycle-by-cycle check against a countdown model, plus directed
// vectors with literal latencies and results.
module tb_comparador_izq_der;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic       start = 1'b0;
    logic [7:0] wordA = '0;
    logic [7:0] wordB = '0;
    logic       busy, done, z, eq;
    logic [2:0] pos;

    int total = 0;
    int bad = 0;

    comparador_izq_der #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .start  (start),
        .wordA  (wordA),
        .wordB  (wordB),
        .busy   (busy),
        .done   (done),
        .z      (z),
        .eq     (eq),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    // Index of the highest differing bit, -1 when the words are equal.
    function automatic int first_diff(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = -1;
        for (int i = 0; i < W; i++) if (a[i] != b[i]) r = i;
        return r;
    endfunction

    // Model: 0 idle, 1 scanning (countdown to done), 2 done.
    int         m_st = 0;
    int         m_cnt = 0;
    int         m_fd;
    logic       m_z = 1'b0, m_eq = 1'b0;
    logic [2:0] m_pos = '0;
    logic       p_z, p_eq;
    logic [2:0] p_pos;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_st = 0; m_cnt = 0; m_z = 1'b0; m_eq = 1'b0; m_pos = '0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_fd  = first_diff(wordA, wordB);
                    p_eq  = (wordA == wordB);
                    p_z   = (wordA <= wordB);
                    p_pos = (m_fd < 0) ? 3'd0 : 3'(m_fd);
                    m_cnt = (m_fd < 0) ? W : W - m_fd;
                    m_st  = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_st = 2; m_z = p_z; m_eq = p_eq; m_pos = p_pos;
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [6:0] want, got;
        want = {m_st != 0, m_st == 2, m_z, m_eq, m_pos};
        got  = {busy, done, z, eq, pos};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL cycle t=%0t got busy/done/z/eq/pos=%b want=%b", $time, got, want);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Waits for done, counting edges since the accepting edge (n0 already elapsed).
    task automatic wait_result(input string name, input int n0, input int lat, input logic ez,
                               input logic eeq, input logic [2:0] epos);
        int n;
        n = n0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < W + 4);
        check({name, "_lat"}, n, lat);
        check({name, "_z"}, z, ez);
        check({name, "_eq"}, eq, eeq);
        check({name, "_pos"}, pos, epos);
    endtask

    task automatic run_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                           input int lat, input logic ez, input logic eeq, input logic [2:0] epos);
        @(posedge clk); #2;
        wordA = a; wordB = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; wordA = ~a; wordB = ~b;
        wait_result(name, 0, lat, ez, eeq, epos);
    endtask

    initial begin
        int n, fd;
        logic [7:0] a, b;
        #1 reset_L = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_zeqpos", {z, eq, pos}, 0);
        #15 reset_L = 1'b1;

        run_cmp("zero_zero", 8'd0, 8'd0, 8, 1'b1, 1'b1, 3'd0);
        run_cmp("e7_81", 8'b11100111, 8'b10000001, 2, 1'b0, 1'b0, 3'd6);
        run_cmp("0_1", 8'd0, 8'd1, 8, 1'b1, 1'b0, 3'd0);
        run_cmp("110_1", 8'd110, 8'd1, 2, 1'b0, 1'b0, 3'd6);

        // Start re-asserted mid-scan with other words must be ignored.
        @(posedge clk); #2;
        wordA = 8'b00001011; wordB = 8'b00001000; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        wordA = 8'hFF; wordB = 8'h00; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_result("ignored_start", 3, 7, 1'b0, 1'b0, 3'd1);

        run_cmp("40_60", 8'b01000000, 8'b01100000, 3, 1'b1, 1'b0, 3'd5);

        // Reset mid-scan aborts; start with release is taken on the very next edge.
        @(posedge clk); #2;
        wordA = 8'd0; wordB = 8'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_L = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_zeqpos", {z, eq, pos}, 0);
        repeat (4) @(posedge clk);
        #2;
        reset_L = 1'b1; wordA = 8'd200; wordB = 8'd201; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_result("after_reset", 0, 8, 1'b1, 1'b0, 3'd0);

        // Start held high: done pulses spaced by scan latency plus DONE and one IDLE cycle.
        @(posedge clk); #2;
        wordA = 8'd5; wordB = 8'd4; start = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 30);
        check("b2b_first", n, 9);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 30);
        check("b2b_gap", n, 10);
        start = 1'b0;
        check("b2b_z", z, 0);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            fd = first_diff(a, b);
            run_cmp("rand", a, b, (fd < 0) ? W : W - fd, a <= b, a == b,
                    (fd < 0) ? 3'd0 : 3'(fd));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparador_izq_der.md
COMPARADOR_IZQ_DER -- requirements
Module: comparador_izq_der

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits (WIDTH >= 2) SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_L  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a comparison; sampled only in IDLE.
REQ-005 wordA  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 wordB  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 busy  output  1  high while a comparison is in progress (SCAN or DONE state).
REQ-008 done  output  1  one-cycle pulse marking valid z/eq/pos.
REQ-009 z  output  1  result: 1 when A <= B (unsigned), else 0.
REQ-010 eq  output  1  1 when A == B.
REQ-011 pos  output  clog2(WIDTH)  index of the first differing bit, scanning MSB to LSB; 0 when eq=1.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-013 IDLE: start=1 at edge N SHALL capture wordA/wordB into internal registers, set scan index to WIDTH-1, and move to SCAN; start=0 SHALL keep IDLE.
REQ-014 SCAN: each edge SHALL compare captured bit A[idx] vs B[idx], from left (MSB) to right (LSB), one bit per cycle.
REQ-015 SCAN, bits differ: z <= (A[idx]==0 && B[idx]==1), eq <= 0, pos <= idx, go to DONE on that same edge.
REQ-016 SCAN, bits equal and idx > 0: idx decrements, remain in SCAN.
REQ-017 SCAN, bits equal and idx == 0: z <= 1, eq <= 1, pos <= 0, go to DONE.
REQ-018 Latency: first difference at bit k SHALL move to DONE at edge N+(WIDTH-k); equal words at edge N+WIDTH.
REQ-019 DONE: done=1 for exactly the cycle in DONE; next edge SHALL return to IDLE unconditionally.
REQ-020 busy SHALL be 1 from edge N until the edge leaving DONE; busy SHALL be 0 in IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-022 Changes on wordA/wordB after the accepting edge SHALL not affect the running comparison.
REQ-023 z, eq, pos SHALL hold their last values in IDLE until the next DONE update.
REQ-024 start held high continuously SHALL yield back-to-back comparisons with one IDLE cycle between them.
REQ-025 The comparison SHALL be unsigned; no arithmetic subtraction is required.

Reset
REQ-026 reset_L=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, z=0, eq=0, pos=0, scan index WIDTH-1, captured words 0.
REQ-027 Reset asserted mid-SCAN or in DONE SHALL abort the comparison with no done pulse.
REQ-028 First start SHALL be accepted on the first rising edge after reset_L deasserts.

Verification
REQ-029 A=8'd0, B=8'd0, start pulse at edge N -> done at edge N+8, z=1, eq=1, pos=0.
REQ-030 A=8'b11100111, B=8'b10000001 -> done at edge N+2, z=0, eq=0, pos=6.
REQ-031 A=8'd0, B=8'd1 -> done at edge N+8, z=1, eq=0, pos=0; A=8'd110, B=8'd1 -> done at edge N+2, z=0, pos=6.
REQ-032 A=8'b00001011, B=8'b00001000 -> done at N+7, z=0, pos=1; start pulsed again at N+3 with other words -> ignored, result unchanged.
REQ-033 reset_L driven low at N+3 during A=8'd0,B=8'd1 scan -> busy/done/z/eq/pos to 0 asynchronously, no done pulse; new start after release completes normally.
REQ-034 Randomised self-check over 1000 word pairs: z == (A<=B), eq == (A==B), pos and latency per REQ-015..018.
